// File: rtl/mem_arbiter_if.sv
// Bundle of the RAM port, fetch and load/store request/response signals.
// The arbiter connects through the slave modport; requesters and RAM connect through master.
interface mem_arbiter_if;
   logic        rdy;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;
   logic        if_to_mc_enable;
   logic [31:0] if_to_mc_pc;
   logic        mc_to_if_done;
   logic [31:0] mc_to_if_result;
   logic        lsb_to_mc_enable;
   logic        lsb_to_mc_wr;
   logic [31:0] lsb_to_mc_addr;
   logic [2:0]  lsb_to_mc_len;
   logic [31:0] lsb_to_mc_data;
   logic        mc_to_lsb_done;
   logic [31:0] mc_to_lsb_result;
   logic        rob_to_mc_clear;

   modport slave (
      input  rdy, mem_din, io_buffer_full,
      input  if_to_mc_enable, if_to_mc_pc,
      input  lsb_to_mc_enable, lsb_to_mc_wr, lsb_to_mc_addr, lsb_to_mc_len, lsb_to_mc_data,
      input  rob_to_mc_clear,
      output mem_dout, mem_a, mem_wr,
      output mc_to_if_done, mc_to_if_result, mc_to_lsb_done, mc_to_lsb_result
   );

   modport master (
      output rdy, mem_din, io_buffer_full,
      output if_to_mc_enable, if_to_mc_pc,
      output lsb_to_mc_enable, lsb_to_mc_wr, lsb_to_mc_addr, lsb_to_mc_len, lsb_to_mc_data,
      output rob_to_mc_clear,
      input  mem_dout, mem_a, mem_wr,
      input  mc_to_if_done, mc_to_if_result, mc_to_lsb_done, mc_to_lsb_result
   );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial controller sharing one 8-bit RAM port between instruction fetch
// and the load/store buffer; little-endian assembly/split, flush abort, IO-full stall.
module mem_arbiter #(
   parameter int unsigned IO_ADDR_BIT = 17
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_t;
   typedef enum logic {OWN_IF, OWN_LSB} owner_t;

   state_t      state_q, state_d;
   owner_t      owner_q, owner_d;
   owner_t      last_q, last_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  scnt_q, scnt_d;
   logic [2:0]  len_q, len_d;
   logic [31:0] base_q, base_d;
   logic [31:0] data_q, data_d;
   logic [31:0] buf_q, buf_d;
   logic [31:0] mem_a_q, mem_a_d;
   logic [7:0]  mem_dout_q, mem_dout_d;
   logic        mem_wr_q, mem_wr_d;
   logic        if_done_q, if_done_d;
   logic        lsb_done_q, lsb_done_d;
   logic [31:0] if_res_q, if_res_d;
   logic [31:0] lsb_res_q, lsb_res_d;

   logic        want_lsb;
   logic [2:0]  len_norm;
   logic [31:0] byte_addr;
   logic [1:0]  rd_idx;

   function automatic logic is_io(input logic [31:0] a);
      return a[IO_ADDR_BIT -: 2] == 2'b11;
   endfunction

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      scnt_d     = scnt_q;
      len_d      = len_q;
      base_d     = base_q;
      data_d     = data_q;
      buf_d      = buf_q;
      mem_a_d    = mem_a_q;
      mem_dout_d = mem_dout_q;
      mem_wr_d   = mem_wr_q;
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      if_res_d   = if_res_q;
      lsb_res_d  = lsb_res_q;
      want_lsb   = 1'b0;
      len_norm   = (bus.lsb_to_mc_len == 3'd1 || bus.lsb_to_mc_len == 3'd2) ? bus.lsb_to_mc_len : 3'd4;
      byte_addr  = base_q + {29'd0, cnt_q};
      rd_idx     = 2'(scnt_q - 3'd1);

      unique case (state_q)
         ST_IDLE: begin
            if (!bus.rob_to_mc_clear && !if_done_q && !lsb_done_q &&
                (bus.if_to_mc_enable || bus.lsb_to_mc_enable)) begin
               want_lsb = bus.lsb_to_mc_enable && (!bus.if_to_mc_enable || last_q == OWN_IF);
               owner_d  = want_lsb ? OWN_LSB : OWN_IF;
               last_d   = owner_d;
               base_d   = want_lsb ? bus.lsb_to_mc_addr : bus.if_to_mc_pc;
               len_d    = want_lsb ? len_norm : 3'd4;
               data_d   = bus.lsb_to_mc_data;
               buf_d    = '0;
               scnt_d   = '0;
               // byte 0 goes out on the grant edge so the first address appears one cycle after the grant
               mem_a_d    = base_d;
               mem_dout_d = bus.lsb_to_mc_data[7:0];
               if (want_lsb && bus.lsb_to_mc_wr) begin
                  state_d = ST_WRITE;
                  if (is_io(base_d) && bus.io_buffer_full) begin
                     mem_wr_d = 1'b0;
                     cnt_d    = 3'd0;
                  end else begin
                     mem_wr_d = 1'b1;
                     cnt_d    = 3'd1;
                  end
               end else begin
                  state_d  = ST_READ;
                  mem_wr_d = 1'b0;
                  cnt_d    = 3'd1;
               end
            end
         end
         ST_READ: begin
            if (bus.rob_to_mc_clear) begin
               state_d  = ST_IDLE;
               mem_wr_d = 1'b0;
               mem_a_d  = '0;
            end else begin
               if (cnt_q < len_q) begin
                  mem_a_d = byte_addr;
                  cnt_d   = cnt_q + 3'd1;
               end
               // RAM data lags its address by two edges; scnt counts edges since grant
               if (scnt_q != 3'd0) buf_d[{rd_idx, 3'b000} +: 8] = bus.mem_din;
               scnt_d = scnt_q + 3'd1;
               if (scnt_q == len_q) begin
                  state_d = ST_IDLE;
                  mem_a_d = '0;
                  if (owner_q == OWN_LSB) begin
                     lsb_done_d = 1'b1;
                     lsb_res_d  = buf_d;
                  end else begin
                     if_done_d = 1'b1;
                     if_res_d  = buf_d;
                  end
               end
            end
         end
         ST_WRITE: begin
            if (cnt_q < len_q) begin
               mem_a_d    = byte_addr;
               mem_dout_d = data_q[{cnt_q[1:0], 3'b000} +: 8];
               if (is_io(byte_addr) && bus.io_buffer_full) begin
                  mem_wr_d = 1'b0;
               end else begin
                  mem_wr_d = 1'b1;
                  cnt_d    = cnt_q + 3'd1;
               end
            end else begin
               state_d    = ST_IDLE;
               mem_wr_d   = 1'b0;
               mem_a_d    = '0;
               lsb_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         last_q     <= OWN_IF;
         cnt_q      <= '0;
         scnt_q     <= '0;
         len_q      <= '0;
         base_q     <= '0;
         data_q     <= '0;
         buf_q      <= '0;
         mem_a_q    <= '0;
         mem_dout_q <= '0;
         mem_wr_q   <= 1'b0;
         if_done_q  <= 1'b0;
         lsb_done_q <= 1'b0;
         if_res_q   <= '0;
         lsb_res_q  <= '0;
      end else if (bus.rdy) begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         scnt_q     <= scnt_d;
         len_q      <= len_d;
         base_q     <= base_d;
         data_q     <= data_d;
         buf_q      <= buf_d;
         mem_a_q    <= mem_a_d;
         mem_dout_q <= mem_dout_d;
         mem_wr_q   <= mem_wr_d;
         if_done_q  <= if_done_d;
         lsb_done_q <= lsb_done_d;
         if_res_q   <= if_res_d;
         lsb_res_q  <= lsb_res_d;
      end
   end

   assign bus.mem_a            = mem_a_q;
   assign bus.mem_dout         = mem_dout_q;
   assign bus.mem_wr           = mem_wr_q;
   assign bus.mc_to_if_done    = if_done_q;
   assign bus.mc_to_if_result  = if_res_q;
   assign bus.mc_to_lsb_done   = lsb_done_q;
   assign bus.mc_to_lsb_result = lsb_res_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM with one-cycle registered read, IO write capture,
// and hand-computed expectations for fetch, contention, stores, stalls, flush and reset.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter #(.IO_ADDR_BIT(17)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] ram [0:1023];
   logic [7:0] ram_q;
   int         io_wr_cnt = 0;
   logic [7:0] io_last = 8'h00;

   // memory system shares the global enable, so a frozen read port keeps its data
   always @(posedge clk) begin
      if (bus.rdy) begin
         ram_q <= ram[bus.mem_a[9:0]];
         if (bus.mem_wr) begin
            if (bus.mem_a[17:16] == 2'b11) begin
               io_wr_cnt <= io_wr_cnt + 1;
               io_last   <= bus.mem_dout;
            end else begin
               ram[bus.mem_a[9:0]] = bus.mem_dout;
            end
         end
      end
   end
   assign bus.mem_din = ram_q;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input bit lsb, input int budget, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(lsb ? bus.mc_to_lsb_done : bus.mc_to_if_done) && n < budget);
   endtask

   initial begin
      int n;
      int seen;
      rst = 1'b1;
      bus.rdy = 1'b1;
      bus.io_buffer_full = 1'b0;
      bus.if_to_mc_enable = 1'b0;
      bus.if_to_mc_pc = '0;
      bus.lsb_to_mc_enable = 1'b0;
      bus.lsb_to_mc_wr = 1'b0;
      bus.lsb_to_mc_addr = '0;
      bus.lsb_to_mc_len = 3'd0;
      bus.lsb_to_mc_data = '0;
      bus.rob_to_mc_clear = 1'b0;
      for (int unsigned i = 0; i < 1024; i++) ram[i] = 8'h00;
      ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'hA0; ram[10'h103] = 8'h00;
      ram[10'h200] = 8'h34; ram[10'h201] = 8'h12; ram[10'h202] = 8'h56; ram[10'h203] = 8'h78;
      ram[10'h3FF] = 8'h77; ram[10'h000] = 8'h88;

      cyc(2);
      chk("rst_mem_a", bus.mem_a, 32'h0);
      chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
      chk("rst_mem_dout", 32'(bus.mem_dout), 32'h0);
      chk("rst_if_done", 32'(bus.mc_to_if_done), 32'h0);
      chk("rst_lsb_done", 32'(bus.mc_to_lsb_done), 32'h0);
      chk("rst_if_res", bus.mc_to_if_result, 32'h0);
      chk("rst_lsb_res", bus.mc_to_lsb_result, 32'h0);
      rst = 1'b0;

      // fetch
      bus.if_to_mc_enable = 1'b1;
      bus.if_to_mc_pc = 32'h100;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         chk("fetch_addr", bus.mem_a, 32'h100 + 32'(k));
         chk("fetch_rd", 32'(bus.mem_wr), 32'h0);
      end
      cyc(1);
      chk("fetch_early", 32'(bus.mc_to_if_done), 32'h0);
      cyc(1);
      chk("fetch_done", 32'(bus.mc_to_if_done), 32'h1);
      chk("fetch_res", bus.mc_to_if_result, 32'h00A00513);
      bus.if_to_mc_enable = 1'b0;
      cyc(1);
      chk("fetch_pulse", 32'(bus.mc_to_if_done), 32'h0);

      // contention after reset: LSB first, then alternate
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      bus.if_to_mc_enable = 1'b1;
      bus.if_to_mc_pc = 32'h100;
      bus.lsb_to_mc_enable = 1'b1;
      bus.lsb_to_mc_wr = 1'b0;
      bus.lsb_to_mc_addr = 32'h200;
      bus.lsb_to_mc_len = 3'd2;
      cyc(1);
      chk("cont1_addr", bus.mem_a, 32'h200);
      wait_done(1'b1, 10, n);
      chk("cont1_lat", 32'(n), 32'd3);
      chk("cont1_res", bus.mc_to_lsb_result, 32'h00001234);
      chk("cont1_if_idle", 32'(bus.mc_to_if_done), 32'h0);
      bus.lsb_to_mc_len = 3'd1;
      cyc(1);
      chk("gap_addr", bus.mem_a, 32'h0);
      cyc(1);
      chk("cont2_addr", bus.mem_a, 32'h100);
      wait_done(1'b0, 10, n);
      chk("cont2_lat", 32'(n), 32'd5);
      chk("cont2_res", bus.mc_to_if_result, 32'h00A00513);
      bus.if_to_mc_enable = 1'b0;
      cyc(2);
      chk("cont3_addr", bus.mem_a, 32'h200);
      wait_done(1'b1, 10, n);
      chk("cont3_lat", 32'(n), 32'd2);
      chk("cont3_res", bus.mc_to_lsb_result, 32'h00000034);
      bus.lsb_to_mc_enable = 1'b0;
      cyc(1);

      // len 3 reads as 4 bytes
      bus.lsb_to_mc_enable = 1'b1;
      bus.lsb_to_mc_len = 3'd3;
      cyc(1);
      chk("len3_addr", bus.mem_a, 32'h200);
      wait_done(1'b1, 10, n);
      chk("len3_lat", 32'(n), 32'd5);
      chk("len3_res", bus.mc_to_lsb_result, 32'h78561234);
      bus.lsb_to_mc_enable = 1'b0;
      cyc(1);

      // address wrap
      bus.lsb_to_mc_enable = 1'b1;
      bus.lsb_to_mc_addr = 32'hFFFF_FFFF;
      bus.lsb_to_mc_len = 3'd2;
      cyc(1);
      chk("wrap_a0", bus.mem_a, 32'hFFFF_FFFF);
      cyc(1);
      chk("wrap_a1", bus.mem_a, 32'h0);
      wait_done(1'b1, 10, n);
      chk("wrap_lat", 32'(n), 32'd2);
      chk("wrap_res", bus.mc_to_lsb_result, 32'h00008877);
      bus.lsb_to_mc_enable = 1'b0;
      cyc(1);

      // 4-byte store
      bus.lsb_to_mc_enable = 1'b1;
      bus.lsb_to_mc_wr = 1'b1;
      bus.lsb_to_mc_addr = 32'h300;
      bus.lsb_to_mc_len = 3'd4;
      bus.lsb_to_mc_data = 32'hDEADBEEF;
      for (int k = 0; k < 4; k++) begin
         cyc(1);
         chk("st_addr", bus.mem_a, 32'h300 + 32'(k));
         chk("st_wr", 32'(bus.mem_wr), 32'h1);
         chk("st_dout", 32'(bus.mem_dout), (32'hDEADBEEF >> (8 * k)) & 32'hFF);
      end
      cyc(1);
      chk("st_done", 32'(bus.mc_to_lsb_done), 32'h1);
      chk("st_wr_off", 32'(bus.mem_wr), 32'h0);
      chk("st_ram", {ram[10'h303], ram[10'h302], ram[10'h301], ram[10'h300]}, 32'hDEADBEEF);
      bus.lsb_to_mc_enable = 1'b0;
      cyc(1);

      // IO store stalled by a full buffer for 3 cycles
      bus.io_buffer_full = 1'b1;
      bus.lsb_to_mc_enable = 1'b1;
      bus.lsb_to_mc_addr = 32'h0003_0000;
      bus.lsb_to_mc_len = 3'd1;
      bus.lsb_to_mc_data = 32'h0000005A;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         chk("io_stall_wr", 32'(bus.mem_wr), 32'h0);
      end
      bus.io_buffer_full = 1'b0;
      cyc(1);
      chk("io_wr", 32'(bus.mem_wr), 32'h1);
      chk("io_addr", bus.mem_a, 32'h0003_0000);
      chk("io_dout", 32'(bus.mem_dout), 32'h5A);
      cyc(1);
      chk("io_done", 32'(bus.mc_to_lsb_done), 32'h1);
      chk("io_count", 32'(io_wr_cnt), 32'd1);
      chk("io_data", 32'(io_last), 32'h5A);
      bus.lsb_to_mc_enable = 1'b0;
      cyc(1);

      // flush aborts a fetch
      bus.if_to_mc_enable = 1'b1;
      bus.if_to_mc_pc = 32'h100;
      cyc(1);
      chk("fl_addr", bus.mem_a, 32'h100);
      cyc(1);
      bus.rob_to_mc_clear = 1'b1;
      cyc(1);
      chk("fl_idle_a", bus.mem_a, 32'h0);
      chk("fl_idle_wr", 32'(bus.mem_wr), 32'h0);
      bus.rob_to_mc_clear = 1'b0;
      bus.if_to_mc_enable = 1'b0;
      seen = 0;
      repeat (8) begin
         cyc(1);
         if (bus.mc_to_if_done) seen++;
      end
      chk("fl_nodone", 32'(seen), 32'd0);

      // flush does not stop a store
      bus.lsb_to_mc_enable = 1'b1;
      bus.lsb_to_mc_wr = 1'b1;
      bus.lsb_to_mc_addr = 32'h310;
      bus.lsb_to_mc_len = 3'd2;
      bus.lsb_to_mc_data = 32'h0000CAFE;
      cyc(1);
      chk("fls_a0", bus.mem_a, 32'h310);
      bus.rob_to_mc_clear = 1'b1;
      cyc(1);
      chk("fls_a1", bus.mem_a, 32'h311);
      chk("fls_wr", 32'(bus.mem_wr), 32'h1);
      cyc(1);
      chk("fls_done", 32'(bus.mc_to_lsb_done), 32'h1);
      chk("fls_ram", {16'h0, ram[10'h311], ram[10'h310]}, 32'h0000CAFE);
      bus.lsb_to_mc_enable = 1'b0;
      bus.lsb_to_mc_wr = 1'b0;
      cyc(1);

      // clear in IDLE blocks the grant
      bus.if_to_mc_enable = 1'b1;
      cyc(1);
      chk("clr_idle_a", bus.mem_a, 32'h0);
      bus.rob_to_mc_clear = 1'b0;
      cyc(1);
      chk("clr_grant_a", bus.mem_a, 32'h100);
      wait_done(1'b0, 10, n);
      chk("clr_lat", 32'(n), 32'd5);
      chk("clr_res", bus.mc_to_if_result, 32'h00A00513);
      bus.if_to_mc_enable = 1'b0;
      cyc(1);

      // rdy low for 5 cycles mid-load
      bus.lsb_to_mc_enable = 1'b1;
      bus.lsb_to_mc_addr = 32'h100;
      bus.lsb_to_mc_len = 3'd4;
      cyc(1);
      chk("rdy_a0", bus.mem_a, 32'h100);
      cyc(1);
      chk("rdy_a1", bus.mem_a, 32'h101);
      bus.rdy = 1'b0;
      cyc(2);
      chk("rdy_frozen", bus.mem_a, 32'h101);
      cyc(3);
      bus.rdy = 1'b1;
      wait_done(1'b1, 10, n);
      chk("rdy_lat", 32'(n), 32'd4);
      chk("rdy_res", bus.mc_to_lsb_result, 32'h00A00513);
      bus.lsb_to_mc_enable = 1'b0;
      cyc(1);

      // reset in the middle of a fetch
      bus.if_to_mc_enable = 1'b1;
      cyc(2);
      rst = 1'b1;
      cyc(1);
      chk("mrst_a", bus.mem_a, 32'h0);
      chk("mrst_wr", 32'(bus.mem_wr), 32'h0);
      chk("mrst_dout", 32'(bus.mem_dout), 32'h0);
      chk("mrst_if_res", bus.mc_to_if_result, 32'h0);
      chk("mrst_lsb_res", bus.mc_to_lsb_result, 32'h0);
      rst = 1'b0;
      bus.if_to_mc_enable = 1'b0;
      seen = 0;
      repeat (8) begin
         cyc(1);
         if (bus.mc_to_if_done || bus.mc_to_lsb_done) seen++;
      end
      chk("mrst_nodone", 32'(seen), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
